bist_signature_checker: RTL and testbench

//  Consumer end of the BIST compaction path. Sits after the RTS controller.
//  On each rising edge of done, it captures the {MISR, SISA} signature pair and compares it with a golden signature.
//  It keeps run and detection counts for coverage, then shifts the captured signature out serially over a valid/ready link.

---
 rtl/bist_signature_checker_pkg.sv | 15 +
 rtl/bist_sat_counter.sv | 26 ++
 rtl/bist_signature_checker.sv | 132 +++++++++++++
 tb/tb_bist_signature_checker.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/bist_signature_checker_pkg.sv
// Shared BIST definitions: FSM state encoding and the default signature widths
// used by the PRPG/SRSG/MISR/SISA blocks.
package bist_signature_checker_pkg;

  localparam int DEFAULT_MISR_SIZE = 56;
  localparam int DEFAULT_SISA_SIZE = 16;
  localparam int DEFAULT_CNT_W     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMP   = 2'd1,
    SHIFT = 2'd2
  } state_t;

endpackage

// File: rtl/bist_sat_counter.sv
// Saturating up-counter with a clear that overrides increment.
module bist_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/bist_signature_checker.sv
// Captures the {MISR, SISA} signature on each rising edge of done, compares it
// with the golden register, keeps run/detect statistics and shifts it out MSB first.
module bist_signature_checker
  import bist_signature_checker_pkg::*;
#(
  parameter int MISR_SIZE = DEFAULT_MISR_SIZE,
  parameter int SISA_SIZE = DEFAULT_SISA_SIZE,
  parameter int CNT_W     = DEFAULT_CNT_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           done,
  input  logic [MISR_SIZE-1:0]           misr_sig,
  input  logic [SISA_SIZE-1:0]           sisa_sig,
  input  logic                           gold_load,
  input  logic [MISR_SIZE+SISA_SIZE-1:0] gold_sig,
  input  logic                           clear_stats,
  output logic                           so_data,
  output logic                           so_valid,
  input  logic                           so_ready,
  output logic                           so_last,
  output logic                           result_valid,
  output logic                           result_fail,
  output logic [CNT_W-1:0]               run_cnt,
  output logic [CNT_W-1:0]               detect_cnt,
  output logic                           overrun,
  output logic                           busy
);

  localparam int SIG_W = MISR_SIZE + SISA_SIZE;
  localparam int BCW   = $clog2(SIG_W);
  localparam logic [BCW-1:0] LAST_IDX = BCW'(SIG_W - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_done_q;
  logic [SIG_W-1:0] r_sig;
  logic [SIG_W-1:0] r_gold;
  logic [BCW-1:0]   r_bit_cnt;
  logic             r_overrun;
  logic             w_done_rise;
  logic             w_fail;
  logic             w_accept;
  logic             w_run_inc;
  logic             w_det_inc;

  assign w_done_rise = done & ~r_done_q;
  assign w_fail      = (r_sig != r_gold);
  assign w_accept    = so_valid & so_ready;
  assign w_run_inc   = (r_state == CMP);
  assign w_det_inc   = (r_state == CMP) & w_fail;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    result_valid = 1'b0;
    result_fail  = 1'b0;
    so_valid     = 1'b0;
    so_data      = 1'b0;
    so_last      = 1'b0;
    busy         = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (w_done_rise) w_state_nxt = CMP;
      end
      CMP: begin
        result_valid = 1'b1;
        result_fail  = w_fail;
        w_state_nxt  = SHIFT;
      end
      SHIFT: begin
        so_valid = 1'b1;
        so_data  = r_sig[SIG_W-1];
        so_last  = (r_bit_cnt == LAST_IDX);
        if (so_ready && so_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A done edge seen outside IDLE is only recorded as an overrun, never captured.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_done_q  <= 1'b0;
      r_sig     <= '0;
      r_gold    <= '0;
      r_bit_cnt <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_done_q <= done;
      if (gold_load) r_gold <= gold_sig;
      if ((r_state == IDLE) && w_done_rise) begin
        r_sig     <= {misr_sig, sisa_sig};
        r_bit_cnt <= '0;
      end else if (w_accept) begin
        r_sig     <= r_sig << 1;
        r_bit_cnt <= r_bit_cnt + BCW'(1);
      end
      if (clear_stats) begin
        r_overrun <= 1'b0;
      end else if (w_done_rise && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign overrun = r_overrun;

  bist_sat_counter #(.W(CNT_W)) u_run_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_run_inc),
    .clr   (clear_stats),
    .count (run_cnt)
  );

  bist_sat_counter #(.W(CNT_W)) u_detect_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_det_inc),
    .clr   (clear_stats),
    .count (detect_cnt)
  );

endmodule

// File: tb/tb_bist_signature_checker.sv
// Bench for bist_signature_checker: a 16-bit-counter instance and a 2-bit-counter
// instance share all inputs and are checked against a run-level reference model.
module tb_bist_signature_checker;

  localparam int SIG_W = 72;
  localparam logic [71:0] G = 72'hC3_5A_96_0F_1E_2D_3C_4B_87;

  logic        clk = 1'b0;
  logic        rstN;
  logic        done;
  logic [55:0] misrSig;
  logic [15:0] sisaSig;
  logic        goldLoad;
  logic [71:0] goldSig;
  logic        clearStats;
  logic        soReady;

  logic        soData, soValid, soLast, resultValid, resultFail, overrun, busy;
  logic [15:0] runCnt, detectCnt;
  logic        bSoData, bSoValid, bSoLast, bResultValid, bResultFail, bOverrun, bBusy;
  logic [1:0]  bRunCnt, bDetectCnt;

  always #5 clk = ~clk;

  bist_signature_checker #(.MISR_SIZE(56), .SISA_SIZE(16), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rstN), .done(done), .misr_sig(misrSig), .sisa_sig(sisaSig),
    .gold_load(goldLoad), .gold_sig(goldSig), .clear_stats(clearStats),
    .so_data(soData), .so_valid(soValid), .so_ready(soReady), .so_last(soLast),
    .result_valid(resultValid), .result_fail(resultFail), .run_cnt(runCnt),
    .detect_cnt(detectCnt), .overrun(overrun), .busy(busy)
  );

  bist_signature_checker #(.MISR_SIZE(56), .SISA_SIZE(16), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rstN), .done(done), .misr_sig(misrSig), .sisa_sig(sisaSig),
    .gold_load(goldLoad), .gold_sig(goldSig), .clear_stats(clearStats),
    .so_data(bSoData), .so_valid(bSoValid), .so_ready(soReady), .so_last(bSoLast),
    .result_valid(bResultValid), .result_fail(bResultFail), .run_cnt(bRunCnt),
    .detect_cnt(bDetectCnt), .overrun(bOverrun), .busy(bBusy)
  );

  int total = 0;
  int bad = 0;

  // Reference model: what a run should leave behind, tracked per run, not per cycle.
  logic [71:0] mGold;
  int          mRun, mDet;
  bit          mOver;
  logic        lastFail;

  typedef struct {
    logic [71:0] sig;
    logic [71:0] gold;
    bit          load;
    int          readyMode;
    bit          expFail;
  } vec_t;

  vec_t tbl[6];

  task automatic checkVal(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkStats(input string tag);
    checkVal({tag, ".run16"}, runCnt, (mRun > 65535) ? 65535 : mRun);
    checkVal({tag, ".det16"}, detectCnt, (mDet > 65535) ? 65535 : mDet);
    checkVal({tag, ".run2"}, bRunCnt, (mRun > 3) ? 3 : mRun);
    checkVal({tag, ".det2"}, bDetectCnt, (mDet > 3) ? 3 : mDet);
    checkVal({tag, ".overrun"}, overrun, mOver);
    checkVal({tag, ".overrun2"}, bOverrun, mOver);
  endtask

  task automatic loadGold(input logic [71:0] g);
    goldLoad = 1'b1;
    goldSig  = g;
    tick();
    goldLoad = 1'b0;
    mGold    = g;
  endtask

  task automatic applyStimulus(input logic [71:0] sig, input int readyMode, input int overrunAt,
                               input bit clearAtCmp, input int resetAt, input bit loadAtCap,
                               input logic [71:0] capGold);
    logic [71:0] got;
    int nbits, lastPos, lastCnt, cycles;
    bit stallBad, rdy, expFail;
    logic pd, pl;
    {misrSig, sisaSig} = sig;
    done = 1'b1;
    if (loadAtCap) begin
      goldLoad = 1'b1;
      goldSig  = capGold;
    end
    tick();
    goldLoad = 1'b0;
    done     = 1'b0;
    if (loadAtCap) mGold = capGold;
    expFail  = (sig != mGold);
    lastFail = resultFail;
    checkVal("cmp.valid", resultValid, 1'b1);
    checkVal("cmp.fail", resultFail, expFail);
    checkVal("cmp.so_valid", soValid, 1'b0);
    if (clearAtCmp) clearStats = 1'b1;
    tick();
    clearStats = 1'b0;
    if (clearAtCmp) begin
      mRun = 0; mDet = 0; mOver = 1'b0;
    end else begin
      mRun++;
      if (expFail) mDet++;
    end
    checkVal("cmp.pulse", resultValid, 1'b0);
    checkStats("cmp");
    got = '0; nbits = 0; lastPos = 0; lastCnt = 0; cycles = 0; stallBad = 1'b0;
    while (soValid && cycles < 1000) begin
      if (resetAt >= 0 && nbits == resetAt) begin
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
        checkVal("rst.busy", busy, 1'b0);
        checkVal("rst.so_valid", soValid, 1'b0);
        mGold = '0; mRun = 0; mDet = 0; mOver = 1'b0;
        checkStats("rst");
        soReady = 1'b0;
        return;
      end
      case (readyMode)
        0:       rdy = 1'b1;
        1:       rdy = (cycles % 3 == 2);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (overrunAt >= 0 && cycles == overrunAt) begin
        done  = 1'b1;
        mOver = 1'b1;
      end
      if (overrunAt >= 0 && cycles == overrunAt + 2) done = 1'b0;
      soReady = rdy;
      pd = soData;
      pl = soLast;
      if (rdy) begin
        got = {got[70:0], soData};
        nbits++;
        if (soLast) begin
          lastPos = nbits;
          lastCnt++;
        end
      end
      tick();
      cycles++;
      if (!rdy && soValid && (soData !== pd || soLast !== pl)) stallBad = 1'b1;
    end
    soReady = 1'b0;
    done    = 1'b0;
    checkVal("stream.timeout", (cycles >= 1000), 1'b0);
    checkVal("stream.data", got, sig);
    checkVal("stream.nbits", nbits, SIG_W);
    checkVal("stream.lastpos", lastPos, SIG_W);
    checkVal("stream.lastcnt", lastCnt, 1);
    checkVal("stream.stall", stallBad, 1'b0);
    checkVal("stream.idle", busy, 1'b0);
    if (readyMode == 0) checkVal("stream.cycles", cycles, SIG_W);
    checkStats("end");
  endtask

  initial begin
    logic [71:0] rs;
    rstN = 1'b0; done = 1'b0; misrSig = '0; sisaSig = '0; goldLoad = 1'b0;
    goldSig = '0; clearStats = 1'b0; soReady = 1'b0;
    mGold = '0; mRun = 0; mDet = 0; mOver = 1'b0; lastFail = 1'b0;

    tbl[0] = '{sig: G,                    gold: G,     load: 1'b1, readyMode: 0, expFail: 1'b0};
    tbl[1] = '{sig: G ^ 72'h1,            gold: G,     load: 1'b0, readyMode: 0, expFail: 1'b1};
    tbl[2] = '{sig: G,                    gold: G,     load: 1'b0, readyMode: 1, expFail: 1'b0};
    tbl[3] = '{sig: ~G,                   gold: G,     load: 1'b0, readyMode: 2, expFail: 1'b1};
    tbl[4] = '{sig: G ^ {1'b1, 71'b0},    gold: G,     load: 1'b0, readyMode: 0, expFail: 1'b1};
    tbl[5] = '{sig: 72'h0,                gold: 72'h0, load: 1'b1, readyMode: 1, expFail: 1'b0};

    tick();
    tick();
    checkVal("reset.result_valid", resultValid, 1'b0);
    checkVal("reset.result_fail", resultFail, 1'b0);
    checkVal("reset.so_valid", soValid, 1'b0);
    checkVal("reset.so_data", soData, 1'b0);
    checkVal("reset.so_last", soLast, 1'b0);
    checkVal("reset.busy", busy, 1'b0);
    checkStats("reset");
    rstN = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].load) loadGold(tbl[i].gold);
      applyStimulus(tbl[i].sig, tbl[i].readyMode, -1, 1'b0, -1, 1'b0, '0);
      checkVal("tbl.fail", lastFail, tbl[i].expFail);
    end

    // Overrun during SHIFT, then clear.
    loadGold(G);
    applyStimulus(G, 0, 5, 1'b0, -1, 1'b0, '0);
    clearStats = 1'b1;
    tick();
    clearStats = 1'b0;
    mRun = 0; mDet = 0; mOver = 1'b0;
    checkStats("clear");

    // Saturation of the 2-bit counters, then clear coincident with CMP.
    for (int i = 0; i < 5; i++) applyStimulus(G ^ 72'h3, 0, -1, 1'b0, -1, 1'b0, '0);
    applyStimulus(G ^ 72'h1, 0, -1, 1'b1, -1, 1'b0, '0);

    // Golden loaded on the capture edge is used by that run.
    applyStimulus(72'h5555_5555_5555_5555_55, 0, -1, 1'b0, -1, 1'b1, 72'h5555_5555_5555_5555_55);

    // Reset in the middle of SHIFT, then a fresh full transfer.
    loadGold(G);
    applyStimulus(G, 0, -1, 1'b0, 10, 1'b0, '0);
    tick();
    loadGold(G);
    applyStimulus(G, 0, -1, 1'b0, -1, 1'b0, '0);

    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 3) == 0) loadGold({$urandom(), $urandom(), 8'($urandom())});
      rs = ($urandom_range(0, 1) == 0) ? mGold : {$urandom(), $urandom(), 8'($urandom())};
      applyStimulus(rs, 2, -1, 1'b0, -1, 1'b0, '0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
